// File: rtl/pmp_pkg.sv
// Shared PMP types, field encodings and config-legalisation helpers for the
// pmp_mchk access checker.
package pmp_pkg;

  localparam int pmpaddrbits = 55;

  typedef logic [63:0]            word64;
  typedef logic [pmpaddrbits-1:0] pmpaddr_type;
  typedef pmpaddr_type            pmpaddr_vec_type [16];

  typedef enum logic [1:0] {
    a_off   = 2'b00,
    a_tor   = 2'b01,
    a_na4   = 2'b10,
    a_napot = 2'b11
  } pmp_a_e;

  typedef enum logic [1:0] {
    acc_fetch = 2'b00,
    acc_load  = 2'b01,
    acc_store = 2'b10,
    acc_rsvd  = 2'b11
  } pmp_acc_e;

  typedef struct packed {
    logic       l;
    logic [1:0] rsvd;
    pmp_a_e     a;
    logic       x;
    logic       w;
    logic       r;
  } pmpcfg_type;

  localparam logic [1:0] prv_m = 2'b11;

  // Low pmpaddr bits that read as ones in NAPOT mode for granularity g.
  function automatic pmpaddr_type napot_force(input int g);
    pmpaddr_type m;
    m = '0;
    for (int i = 0; i < pmpaddrbits; i++)
      if (i < g - 1) m[i] = 1'b1;
    return m;
  endfunction

  function automatic pmpcfg_type cfg_legalize(input logic [7:0] d, input int g);
    pmpcfg_type c;
    c = pmpcfg_type'(d);
    c.rsvd = 2'b00;
    if (c.w && !c.r) c.w = 1'b0;
    if (g >= 1 && c.a == a_na4) c.a = a_off;
    return c;
  endfunction

endpackage

// File: rtl/pmp_mchk_entry.sv
// Single PMP entry: combinational address match and permission for one request.
module pmp_mchk_entry
  import pmp_pkg::*;
#(
  parameter int pmp_msb    = 55,
  parameter int pmp_g      = 10,
  parameter int pmp_no_tor = 0
) (
  input  logic [pmp_msb:0] addr,
  input  logic [1:0]       acc,
  input  logic             priv_m,
  input  pmpcfg_type       cfg,
  input  pmpaddr_type      addr_lo,
  input  pmpaddr_type      addr_hi,
  output logic             match,
  output logic             ok
);

  localparam pmpaddr_type force_ones = napot_force(pmp_g);

  pmpaddr_type waddr;
  pmpaddr_type napot_base;
  pmpaddr_type napot_mask;
  logic        perm;
  logic        unused_bits;

  assign waddr       = pmpaddr_type'(addr[pmp_msb:2]);
  assign unused_bits = ^{addr[1:0], cfg.rsvd};
  assign napot_base  = addr_hi | force_ones;
  // Trailing ones plus the first zero above them select the region size.
  assign napot_mask  = napot_base ^ (napot_base + pmpaddr_type'(1));

  always_comb begin
    match = 1'b0;
    case (cfg.a)
      a_tor:   match = (pmp_no_tor == 0) && (waddr >= addr_lo) && (waddr < addr_hi);
      a_na4:   match = (waddr == addr_hi);
      a_napot: match = ((waddr ^ napot_base) & ~napot_mask) == '0;
      default: match = 1'b0;
    endcase
  end

  always_comb begin
    perm = 1'b0;
    case (acc)
      acc_fetch: perm = cfg.x;
      acc_load:  perm = cfg.r;
      acc_store: perm = cfg.w;
      default:   perm = 1'b0;
    endcase
  end

  assign ok = (acc != acc_rsvd) && ((priv_m && !cfg.l) || perm);

endmodule

// File: rtl/pmp_mchk.sv
// Multi-channel PMP access checker: config register file, request capture,
// per-entry match stage, priority select, and denied-access counter.
module pmp_mchk
  import pmp_pkg::*;
#(
  parameter int pmp_entries = 16,
  parameter int pmp_msb     = 55,
  parameter int pmp_g       = 10,
  parameter int pmp_no_tor  = 0,
  parameter int nch         = 2
) (
  input  logic                       clk300p,
  input  logic                       rstn,
  input  logic                       cfg_we,
  input  logic                       addr_we,
  input  logic [3:0]                 cfg_idx,
  input  logic [7:0]                 cfg_data,
  input  logic [pmpaddrbits-1:0]     addr_data,
  input  logic [1:0]                 prv,
  input  logic [1:0]                 mpp,
  input  logic                       mprv,
  input  logic [nch-1:0]             req_valid,
  output logic [nch-1:0]             req_ready,
  input  logic [nch-1:0][pmp_msb:0]  req_addr,
  input  logic [nch-1:0][1:0]        req_acc,
  output logic [nch-1:0]             rsp_valid,
  output logic [nch-1:0]             rsp_ok,
  output logic [15:0]                fault_cnt,
  input  logic                       cnt_clr
);

  pmpcfg_type      cfg_q [16];
  pmpaddr_vec_type addr_q;
  logic [15:0]     tor_lock;

  logic [nch-1:0]                  s0_valid, s0_m;
  logic [nch-1:0][pmp_msb:0]       s0_addr;
  logic [nch-1:0][1:0]             s0_acc;
  logic [nch-1:0][pmp_entries-1:0] e_match, e_ok, s1_match, s1_ok;
  logic [nch-1:0]                  s1_valid, s1_nomatch_ok, nomatch_ok, sel_ok;
  logic [2:0]                      n_fault;
  logic [16:0]                     cnt_sum;

  assign req_ready = {nch{!(cfg_we | addr_we)}};

  // A locked TOR entry also freezes the pmpaddr below it (its lower bound).
  always_comb begin
    tor_lock = '0;
    for (int i = 0; i < pmp_entries - 1; i++)
      tor_lock[i] = cfg_q[i+1].l && (cfg_q[i+1].a == a_tor);
  end

  always_ff @(posedge clk300p or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 16; i++) begin
        cfg_q[i]  <= '0;
        addr_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < pmp_entries; i++) begin
        if (cfg_we && cfg_idx == 4'(i) && !cfg_q[i].l)
          cfg_q[i] <= cfg_legalize(cfg_data, pmp_g);
        if (addr_we && cfg_idx == 4'(i) && !cfg_q[i].l && !tor_lock[i])
          addr_q[i] <= addr_data;
      end
    end
  end

  always_ff @(posedge clk300p or negedge rstn) begin
    if (!rstn) begin
      s0_valid <= '0;
      s0_m     <= '0;
      s0_addr  <= '0;
      s0_acc   <= '0;
    end else begin
      s0_valid <= req_valid & req_ready;
      for (int c = 0; c < nch; c++) begin
        if (req_valid[c] && req_ready[c]) begin
          s0_addr[c] <= req_addr[c];
          s0_acc[c]  <= req_acc[c];
          s0_m[c]    <= (((prv == prv_m) && mprv && (req_acc[c] != acc_fetch)) ? mpp : prv) == prv_m;
        end
      end
    end
  end

  for (genvar c = 0; c < nch; c++) begin : g_ch
    for (genvar e = 0; e < pmp_entries; e++) begin : g_ent
      pmpaddr_type lo;
      if (e == 0) begin : g_first
        assign lo = '0;
      end else begin : g_rest
        assign lo = addr_q[e-1];
      end
      pmp_mchk_entry #(
        .pmp_msb   (pmp_msb),
        .pmp_g     (pmp_g),
        .pmp_no_tor(pmp_no_tor)
      ) u_entry (
        .addr   (s0_addr[c]),
        .acc    (s0_acc[c]),
        .priv_m (s0_m[c]),
        .cfg    (cfg_q[e]),
        .addr_lo(lo),
        .addr_hi(addr_q[e]),
        .match  (e_match[c][e]),
        .ok     (e_ok[c][e])
      );
    end
    assign nomatch_ok[c] = s0_m[c] && (s0_acc[c] != acc_rsvd);
  end

  always_ff @(posedge clk300p or negedge rstn) begin
    if (!rstn) begin
      s1_valid      <= '0;
      s1_match      <= '0;
      s1_ok         <= '0;
      s1_nomatch_ok <= '0;
    end else begin
      s1_valid      <= s0_valid;
      s1_match      <= e_match;
      s1_ok         <= e_ok;
      s1_nomatch_ok <= nomatch_ok;
    end
  end

  // Walk from the top so the lowest-numbered matching entry is applied last.
  always_comb begin
    sel_ok = s1_nomatch_ok;
    for (int c = 0; c < nch; c++)
      for (int e = pmp_entries - 1; e >= 0; e--)
        if (s1_match[c][e]) sel_ok[c] = s1_ok[c][e];
  end

  always_ff @(posedge clk300p or negedge rstn) begin
    if (!rstn) begin
      rsp_valid <= '0;
      rsp_ok    <= '0;
    end else begin
      rsp_valid <= s1_valid;
      rsp_ok    <= sel_ok & s1_valid;
    end
  end

  always_comb begin
    n_fault = '0;
    for (int c = 0; c < nch; c++)
      n_fault = n_fault + 3'(rsp_valid[c] & ~rsp_ok[c]);
    cnt_sum = {1'b0, fault_cnt} + 17'(n_fault);
  end

  always_ff @(posedge clk300p or negedge rstn) begin
    if (!rstn)        fault_cnt <= '0;
    else if (cnt_clr) fault_cnt <= '0;
    else              fault_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

endmodule

// File: tb/tb_pmp_mchk.sv
// Directed self-checking bench for pmp_mchk (default parameters, two channels).
module tb_pmp_mchk;

  logic             clk300p = 1'b0;
  logic             rstn;
  logic             cfg_we, addr_we;
  logic [3:0]       cfg_idx;
  logic [7:0]       cfg_data;
  logic [54:0]      addr_data;
  logic [1:0]       prv, mpp;
  logic             mprv;
  logic [1:0]       req_valid, req_ready;
  logic [1:0][55:0] req_addr;
  logic [1:0][1:0]  req_acc;
  logic [1:0]       rsp_valid, rsp_ok;
  logic [15:0]      fault_cnt;
  logic             cnt_clr;

  int checks = 0;
  int failures = 0;

  always #5 clk300p = ~clk300p;

  pmp_mchk #(.pmp_entries(16), .pmp_msb(55), .pmp_g(10), .pmp_no_tor(0), .nch(2)) dut (
    .clk300p(clk300p), .rstn(rstn), .cfg_we(cfg_we), .addr_we(addr_we),
    .cfg_idx(cfg_idx), .cfg_data(cfg_data), .addr_data(addr_data),
    .prv(prv), .mpp(mpp), .mprv(mprv),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_acc(req_acc),
    .rsp_valid(rsp_valid), .rsp_ok(rsp_ok), .fault_cnt(fault_cnt), .cnt_clr(cnt_clr)
  );

  task automatic tick();
    @(posedge clk300p);
    @(negedge clk300p);
  endtask

  task automatic do_reset();
    rstn = 1'b0; cfg_we = 1'b0; addr_we = 1'b0; req_valid = '0; cnt_clr = 1'b0;
    prv = 2'b00; mpp = 2'b00; mprv = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic wr_cfg(input logic [3:0] idx, input logic [7:0] d);
    cfg_we = 1'b1; cfg_idx = idx; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic wr_addr(input logic [3:0] idx, input logic [54:0] d);
    addr_we = 1'b1; cfg_idx = idx; addr_data = d;
    tick();
    addr_we = 1'b0;
  endtask

  // One request on one channel; returns rsp_valid one cycle early, then the response.
  task automatic single(input int ch, input logic [55:0] a, input logic [1:0] acc,
                        output logic ve, output logic v, output logic ok);
    req_valid = '0; req_valid[ch] = 1'b1; req_addr[ch] = a; req_acc[ch] = acc;
    tick();
    req_valid = '0;
    tick();
    ve = rsp_valid[ch];
    tick();
    v = rsp_valid[ch]; ok = rsp_ok[ch];
  endtask

  task automatic test_reset();
    rstn = 1'b0; cfg_we = 1'b0; addr_we = 1'b0; req_valid = '0; cnt_clr = 1'b0;
    cfg_idx = '0; cfg_data = '0; addr_data = '0; req_addr = '0; req_acc = '0;
    prv = 2'b00; mpp = 2'b00; mprv = 1'b0;
    #12;
    checks++; if ({rsp_valid, rsp_ok} !== 4'b0000) begin failures++;
      $display("FAIL reset_rsp got=%b exp=0000", {rsp_valid, rsp_ok}); end
    checks++; if (fault_cnt !== 16'h0) begin failures++;
      $display("FAIL reset_fault_cnt got=%h exp=0000", fault_cnt); end
    checks++; if (req_ready !== 2'b11) begin failures++;
      $display("FAIL reset_ready got=%b exp=11", req_ready); end
    @(negedge clk300p);
    rstn = 1'b1;
    tick();
    checks++; if ({rsp_valid, fault_cnt} !== 18'h0) begin failures++;
      $display("FAIL post_reset got=%b/%h exp=00/0000", rsp_valid, fault_cnt); end
  endtask

  task automatic test_napot();
    logic ve, v, ok;
    do_reset();
    wr_addr(4'd0, 55'h2000_01FF); wr_cfg(4'd0, 8'h19);
    single(0, 56'h8000_0FFC, 2'b01, ve, v, ok);
    checks++; if ({ve, v, ok} !== 3'b011) begin failures++;
      $display("FAIL napot_top got=%b exp=011", {ve, v, ok}); end
    single(0, 56'h8000_1000, 2'b01, ve, v, ok);
    checks++; if ({ve, v, ok} !== 3'b010) begin failures++;
      $display("FAIL napot_above got=%b exp=010", {ve, v, ok}); end
    tick();
    checks++; if (fault_cnt !== 16'd1) begin failures++;
      $display("FAIL fault_one got=%0d exp=1", fault_cnt); end
    single(1, 56'h8000_0000, 2'b10, ve, v, ok);
    checks++; if ({ve, v, ok} !== 3'b010) begin failures++;
      $display("FAIL napot_store_w0 got=%b exp=010", {ve, v, ok}); end
    single(1, 56'h7FFF_FFFC, 2'b01, ve, v, ok);
    checks++; if ({ve, v, ok} !== 3'b010) begin failures++;
      $display("FAIL napot_below got=%b exp=010", {ve, v, ok}); end
    wr_addr(4'd0, 55'h2000_0000);
    single(0, 56'h8000_0800, 2'b01, ve, v, ok);
    checks++; if ({ve, v, ok} !== 3'b011) begin failures++;
      $display("FAIL napot_gran_min got=%b exp=011", {ve, v, ok}); end
    checks++; if (fault_cnt !== 16'd3) begin failures++;
      $display("FAIL fault_three got=%0d exp=3", fault_cnt); end
  endtask

  task automatic test_priority();
    logic ve, v, ok;
    do_reset();
    wr_addr(4'd0, 55'h400);  wr_cfg(4'd0, 8'h09);
    wr_addr(4'd1, 55'h7FFF); wr_cfg(4'd1, 8'h1C);
    single(1, 56'h100, 2'b00, ve, v, ok);
    checks++; if ({ve, v, ok} !== 3'b010) begin failures++;
      $display("FAIL prio_tor_x0 got=%b exp=010", {ve, v, ok}); end
    single(0, 56'h1000, 2'b00, ve, v, ok);
    checks++; if ({ve, v, ok} !== 3'b011) begin failures++;
      $display("FAIL tor_upper_excl got=%b exp=011", {ve, v, ok}); end
    single(0, 56'hFFC, 2'b00, ve, v, ok);
    checks++; if ({ve, v, ok} !== 3'b010) begin failures++;
      $display("FAIL tor_last_word got=%b exp=010", {ve, v, ok}); end
    single(1, 56'hFFC, 2'b01, ve, v, ok);
    checks++; if ({ve, v, ok} !== 3'b011) begin failures++;
      $display("FAIL tor_load_r got=%b exp=011", {ve, v, ok}); end
  endtask

  task automatic test_lock();
    logic ve, v, ok;
    do_reset();
    wr_addr(4'd3, 55'h2000_01FF); wr_cfg(4'd3, 8'h98); wr_cfg(4'd3, 8'h1F);
    prv = 2'b11;
    single(0, 56'h8000_0010, 2'b01, ve, v, ok);
    checks++; if ({ve, v, ok} !== 3'b010) begin failures++;
      $display("FAIL lock_m_load got=%b exp=010", {ve, v, ok}); end
    wr_addr(4'd3, 55'h0);
    single(0, 56'h8000_0010, 2'b01, ve, v, ok);
    checks++; if ({ve, v, ok} !== 3'b010) begin failures++;
      $display("FAIL lock_addr_ignored got=%b exp=010", {ve, v, ok}); end
    prv = 2'b00;
    wr_addr(4'd4, 55'h100); wr_addr(4'd5, 55'h200); wr_cfg(4'd5, 8'h89);
    wr_addr(4'd4, 55'h180);
    single(1, 56'h500, 2'b01, ve, v, ok);
    checks++; if ({ve, v, ok} !== 3'b011) begin failures++;
      $display("FAIL tor_lock_prev_addr got=%b exp=011", {ve, v, ok}); end
    wr_addr(4'd6, 55'h2800_0000); wr_cfg(4'd6, 8'h91);
    prv = 2'b11;
    single(0, 56'hA000_0000, 2'b00, ve, v, ok);
    checks++; if ({ve, v, ok} !== 3'b011) begin failures++;
      $display("FAIL na4_to_off got=%b exp=011", {ve, v, ok}); end
    wr_addr(4'd7, 55'h2400_01FF); wr_cfg(4'd7, 8'h1A);
    prv = 2'b00;
    single(1, 56'h9000_0004, 2'b10, ve, v, ok);
    checks++; if ({ve, v, ok} !== 3'b010) begin failures++;
      $display("FAIL w_without_r got=%b exp=010", {ve, v, ok}); end
  endtask

  task automatic test_mprv();
    logic ve, v, ok;
    do_reset();
    prv = 2'b11; mprv = 1'b1; mpp = 2'b00;
    single(0, 56'h1000, 2'b01, ve, v, ok);
    checks++; if ({ve, v, ok} !== 3'b010) begin failures++;
      $display("FAIL mprv_load got=%b exp=010", {ve, v, ok}); end
    single(0, 56'h1000, 2'b00, ve, v, ok);
    checks++; if ({ve, v, ok} !== 3'b011) begin failures++;
      $display("FAIL mprv_fetch got=%b exp=011", {ve, v, ok}); end
    single(1, 56'h1000, 2'b10, ve, v, ok);
    checks++; if ({ve, v, ok} !== 3'b010) begin failures++;
      $display("FAIL mprv_store got=%b exp=010", {ve, v, ok}); end
    mpp = 2'b11;
    single(1, 56'h1000, 2'b01, ve, v, ok);
    checks++; if ({ve, v, ok} !== 3'b011) begin failures++;
      $display("FAIL mprv_mpp_m got=%b exp=011", {ve, v, ok}); end
    mprv = 1'b0;
    single(0, 56'h1000, 2'b11, ve, v, ok);
    checks++; if ({ve, v, ok} !== 3'b010) begin failures++;
      $display("FAIL acc_rsvd_m got=%b exp=010", {ve, v, ok}); end
    prv = 2'b01; mprv = 1'b1;
    single(0, 56'h1000, 2'b01, ve, v, ok);
    checks++; if ({ve, v, ok} !== 3'b010) begin failures++;
      $display("FAIL mprv_non_m got=%b exp=010", {ve, v, ok}); end
    tick();
    checks++; if (fault_cnt !== 16'd4) begin failures++;
      $display("FAIL mprv_fault_cnt got=%0d exp=4", fault_cnt); end
  endtask

  task automatic test_back_to_back();
    logic ve, v, ok;
    do_reset();
    wr_addr(4'd0, 55'h2000_01FF); wr_cfg(4'd0, 8'h1B);
    req_valid = 2'b11;
    req_addr[0] = 56'h8000_0000; req_acc[0] = 2'b01;
    req_addr[1] = 56'h8000_1000; req_acc[1] = 2'b10;
    tick();
    req_addr[0] = 56'h8000_0000; req_acc[0] = 2'b00;
    req_addr[1] = 56'h8000_0FF0; req_acc[1] = 2'b10;
    tick();
    req_valid = 2'b00;
    tick();
    checks++; if ({rsp_valid, rsp_ok} !== 4'b1101) begin failures++;
      $display("FAIL b2b_first got=%b exp=1101", {rsp_valid, rsp_ok}); end
    tick();
    checks++; if ({rsp_valid, rsp_ok} !== 4'b1110) begin failures++;
      $display("FAIL b2b_second got=%b exp=1110", {rsp_valid, rsp_ok}); end
    tick();
    checks++; if ({rsp_valid, fault_cnt} !== {2'b00, 16'd2}) begin failures++;
      $display("FAIL b2b_drain got=%b/%0d exp=00/2", rsp_valid, fault_cnt); end
    req_valid = 2'b01; req_addr[0] = 56'h8000_0000; req_acc[0] = 2'b01;
    tick();
    req_valid = 2'b00; cfg_we = 1'b1; cfg_idx = 4'd0; cfg_data = 8'h18;
    tick();
    cfg_we = 1'b0;
    tick();
    checks++; if ({rsp_valid[0], rsp_ok[0]} !== 2'b11) begin failures++;
      $display("FAIL cfg_after_accept got=%b exp=11", {rsp_valid[0], rsp_ok[0]}); end
    single(0, 56'h8000_0000, 2'b01, ve, v, ok);
    checks++; if ({ve, v, ok} !== 3'b010) begin failures++;
      $display("FAIL cfg_new_applies got=%b exp=010", {ve, v, ok}); end
  endtask

  task automatic test_saturate();
    do_reset();
    req_addr = '0; req_acc[0] = 2'b01; req_acc[1] = 2'b01;
    req_valid = 2'b11;
    for (int i = 0; i < 32767; i++) @(posedge clk300p);
    @(negedge clk300p);
    req_valid = 2'b00;
    repeat (4) tick();
    checks++; if (fault_cnt !== 16'hFFFE) begin failures++;
      $display("FAIL sat_pre got=%h exp=FFFE", fault_cnt); end
    req_valid = 2'b11; tick(); req_valid = 2'b00;
    repeat (4) tick();
    checks++; if (fault_cnt !== 16'hFFFF) begin failures++;
      $display("FAIL sat_reach got=%h exp=FFFF", fault_cnt); end
    req_valid = 2'b11; tick(); req_valid = 2'b00;
    repeat (4) tick();
    checks++; if (fault_cnt !== 16'hFFFF) begin failures++;
      $display("FAIL sat_hold got=%h exp=FFFF", fault_cnt); end
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    checks++; if (fault_cnt !== 16'h0) begin failures++;
      $display("FAIL cnt_clr got=%h exp=0000", fault_cnt); end
    req_valid = 2'b11;
    repeat (4) tick();
    checks++; if (fault_cnt !== 16'd2) begin failures++;
      $display("FAIL stream_count got=%0d exp=2", fault_cnt); end
    cnt_clr = 1'b1; tick();
    checks++; if ({rsp_valid, fault_cnt} !== {2'b11, 16'h0}) begin failures++;
      $display("FAIL clr_wins got=%b/%h exp=11/0000", rsp_valid, fault_cnt); end
    cnt_clr = 1'b0; tick();
    checks++; if (fault_cnt !== 16'd2) begin failures++;
      $display("FAIL after_clr_inc got=%0d exp=2", fault_cnt); end
    req_valid = 2'b00;
    repeat (4) tick();
  endtask

  task automatic test_midflight_reset();
    int seen;
    do_reset();
    prv = 2'b11;
    req_valid = 2'b01; req_addr[0] = 56'h1000; req_acc[0] = 2'b01;
    tick();
    req_valid = 2'b00; rstn = 1'b0;
    tick();
    rstn = 1'b1;
    seen = 0;
    repeat (4) begin
      tick();
      if (rsp_valid !== 2'b00) seen++;
    end
    checks++; if (seen !== 0) begin failures++;
      $display("FAIL midflight_drop got=%0d responses exp=0", seen); end
  endtask

  task automatic test_ready();
    int seen;
    cfg_we = 1'b1; cfg_idx = 4'd9; cfg_data = 8'h00;
    req_valid = 2'b11; req_addr = '0; req_acc[0] = 2'b01; req_acc[1] = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b00) begin failures++;
      $display("FAIL ready_cfg_we got=%b exp=00", req_ready); end
    tick();
    cfg_we = 1'b0; addr_we = 1'b1; addr_data = '0;
    #1;
    checks++; if (req_ready !== 2'b00) begin failures++;
      $display("FAIL ready_addr_we got=%b exp=00", req_ready); end
    tick();
    addr_we = 1'b0; req_valid = 2'b00;
    #1;
    checks++; if (req_ready !== 2'b11) begin failures++;
      $display("FAIL ready_idle got=%b exp=11", req_ready); end
    seen = 0;
    repeat (4) begin
      tick();
      if (rsp_valid !== 2'b00) seen++;
    end
    checks++; if (seen !== 0) begin failures++;
      $display("FAIL no_accept_while_busy got=%0d responses exp=0", seen); end
  endtask

  initial begin
    test_reset();
    test_napot();
    test_priority();
    test_lock();
    test_mprv();
    test_back_to_back();
    test_saturate();
    test_midflight_reset();
    test_ready();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
